// File: rtl/sal_cmd_sched.sv
// Per-channel DDR command scheduler: masks requests by inter-bank timing,
// grants one command per cycle and registers it onto the command path.
module sal_cmd_sched #(
   parameter  int NUM_BANKS = 4,
   parameter  int RA_W      = 16,
   parameter  int CA_W      = 10,
   parameter  int TW        = 5,
   localparam int BW        = $clog2(NUM_BANKS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_BANKS-1:0]      act_req_i,
   input  logic [NUM_BANKS-1:0]      rd_req_i,
   input  logic [NUM_BANKS-1:0]      wr_req_i,
   input  logic [NUM_BANKS-1:0]      pre_req_i,
   input  logic [NUM_BANKS-1:0]      ref_req_i,
   input  logic [NUM_BANKS*RA_W-1:0] ra_i,
   input  logic [NUM_BANKS*CA_W-1:0] ca_i,
   input  logic [TW-1:0]             t_rrd_m1,
   input  logic [TW-1:0]             t_ccd_m1,
   input  logic [TW-1:0]             t_wtr_m1,
   input  logic [TW-1:0]             t_rtw_m1,
   output logic [NUM_BANKS-1:0]      act_gnt_o,
   output logic [NUM_BANKS-1:0]      rd_gnt_o,
   output logic [NUM_BANKS-1:0]      wr_gnt_o,
   output logic [NUM_BANKS-1:0]      pre_gnt_o,
   output logic [NUM_BANKS-1:0]      ref_gnt_o,
   output logic                      cmd_valid_o,
   output logic [2:0]                cmd_o,
   output logic [BW-1:0]             cmd_bk_o,
   output logic [RA_W-1:0]           cmd_addr_o
);

   typedef enum logic [2:0] {
      CMD_NOP = 3'd0,
      CMD_ACT = 3'd1,
      CMD_RD  = 3'd2,
      CMD_WR  = 3'd3,
      CMD_PRE = 3'd4,
      CMD_REF = 3'd5
   } cmd_e;

   logic [TW-1:0]        rrd_q, rrd_d, ccd_q, ccd_d, wtr_q, wtr_d, rtw_q, rtw_d;
   logic [BW-1:0]        ref_ptr_q, ref_ptr_d, col_ptr_q, col_ptr_d;
   logic [BW-1:0]        act_ptr_q, act_ptr_d, pre_ptr_q, pre_ptr_d;
   logic                 cmd_valid_q, cmd_valid_d;
   cmd_e                 cmd_q, cmd_d;
   logic [BW-1:0]        bk_q, bk_d;
   logic [RA_W-1:0]      addr_q, addr_d;

   logic [NUM_BANKS-1:0] rd_m, wr_m, col_m, act_m, onehot;
   logic                 ref_hit, col_hit, act_hit, pre_hit;
   logic [BW-1:0]        ref_win, col_win, act_win, pre_win, win;
   cmd_e                 sel;

   // First requesting bank at or after ptr, wrapping; returns {found, index}.
   function automatic logic [BW:0] rr_pick(input logic [NUM_BANKS-1:0] req,
                                           input logic [BW-1:0]        ptr);
      logic          found;
      logic [BW-1:0] idx, cand;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
         cand = ptr + BW'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

   assign rd_m  = (ccd_q == '0 && wtr_q == '0) ? rd_req_i  : '0;
   assign wr_m  = (ccd_q == '0 && rtw_q == '0) ? wr_req_i  : '0;
   assign act_m = (rrd_q == '0)                ? act_req_i : '0;
   assign col_m = rd_m | wr_m;

   assign {ref_hit, ref_win} = rr_pick(ref_req_i, ref_ptr_q);
   assign {col_hit, col_win} = rr_pick(col_m,     col_ptr_q);
   assign {act_hit, act_win} = rr_pick(act_m,     act_ptr_q);
   assign {pre_hit, pre_win} = rr_pick(pre_req_i, pre_ptr_q);

   always_comb begin
      sel = CMD_NOP;
      win = '0;
      if (ref_hit) begin
         sel = CMD_REF;
         win = ref_win;
      end else if (col_hit) begin
         // RD wins when a bank illegally raises both rd and wr.
         sel = rd_m[col_win] ? CMD_RD : CMD_WR;
         win = col_win;
      end else if (act_hit) begin
         sel = CMD_ACT;
         win = act_win;
      end else if (pre_hit) begin
         sel = CMD_PRE;
         win = pre_win;
      end
      if (!rst_n) begin
         sel = CMD_NOP;
         win = '0;
      end

      onehot      = '0;
      onehot[win] = 1'b1;
      act_gnt_o   = (sel == CMD_ACT) ? onehot : '0;
      rd_gnt_o    = (sel == CMD_RD)  ? onehot : '0;
      wr_gnt_o    = (sel == CMD_WR)  ? onehot : '0;
      pre_gnt_o   = (sel == CMD_PRE) ? onehot : '0;
      ref_gnt_o   = (sel == CMD_REF) ? onehot : '0;

      rrd_d = (rrd_q != '0) ? rrd_q - TW'(1) : rrd_q;
      ccd_d = (ccd_q != '0) ? ccd_q - TW'(1) : ccd_q;
      wtr_d = (wtr_q != '0) ? wtr_q - TW'(1) : wtr_q;
      rtw_d = (rtw_q != '0) ? rtw_q - TW'(1) : rtw_q;
      if (sel == CMD_ACT) rrd_d = t_rrd_m1;
      if (sel == CMD_RD || sel == CMD_WR) ccd_d = t_ccd_m1;
      if (sel == CMD_WR) wtr_d = t_wtr_m1;
      if (sel == CMD_RD) rtw_d = t_rtw_m1;

      ref_ptr_d = ref_ptr_q;
      col_ptr_d = col_ptr_q;
      act_ptr_d = act_ptr_q;
      pre_ptr_d = pre_ptr_q;
      case (sel)
         CMD_REF:        ref_ptr_d = win + BW'(1);
         CMD_RD, CMD_WR: col_ptr_d = win + BW'(1);
         CMD_ACT:        act_ptr_d = win + BW'(1);
         CMD_PRE:        pre_ptr_d = win + BW'(1);
         default:        ;
      endcase

      cmd_valid_d = (sel != CMD_NOP);
      cmd_d       = sel;
      bk_d        = win;
      addr_d      = '0;
      case (sel)
         CMD_ACT:        addr_d = ra_i[int'(win)*RA_W +: RA_W];
         CMD_RD, CMD_WR: addr_d[CA_W-1:0] = ca_i[int'(win)*CA_W +: CA_W];
         default:        ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rrd_q       <= '0;
         ccd_q       <= '0;
         wtr_q       <= '0;
         rtw_q       <= '0;
         ref_ptr_q   <= '0;
         col_ptr_q   <= '0;
         act_ptr_q   <= '0;
         pre_ptr_q   <= '0;
         cmd_valid_q <= 1'b0;
         cmd_q       <= CMD_NOP;
         bk_q        <= '0;
         addr_q      <= '0;
      end else begin
         rrd_q       <= rrd_d;
         ccd_q       <= ccd_d;
         wtr_q       <= wtr_d;
         rtw_q       <= rtw_d;
         ref_ptr_q   <= ref_ptr_d;
         col_ptr_q   <= col_ptr_d;
         act_ptr_q   <= act_ptr_d;
         pre_ptr_q   <= pre_ptr_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_q       <= cmd_d;
         bk_q        <= bk_d;
         addr_q      <= addr_d;
      end
   end

   assign cmd_valid_o = cmd_valid_q;
   assign cmd_o       = cmd_q;
   assign cmd_bk_o    = bk_q;
   assign cmd_addr_o  = addr_q;

endmodule

// File: tb/tb_sal_cmd_sched.sv
// Bench for sal_cmd_sched: directed vector table, hand-written corner
// sequences and random traffic against an integer-level scheduling model.
module tb_sal_cmd_sched;

   localparam int N    = 4;
   localparam int RA_W = 16;
   localparam int CA_W = 10;
   localparam int TW   = 5;
   localparam int BW   = $clog2(N);

   logic              clk, rst_n;
   logic [N-1:0]      act_r, rd_r, wr_r, pre_r, ref_r;
   logic [N*RA_W-1:0] ra;
   logic [N*CA_W-1:0] ca;
   logic [TW-1:0]     trrd, tccd, twtr, trtw;
   logic [N-1:0]      act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
   logic              cmd_valid;
   logic [2:0]        cmd;
   logic [BW-1:0]     cmd_bk;
   logic [RA_W-1:0]   cmd_addr;
   logic [5*N-1:0]    dut_gnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: plain integers, one pointer per class (0 REF,1 COL,2 ACT,3 PRE).
   int              m_rrd, m_ccd, m_wtr, m_rtw;
   int              m_ptr[4];
   logic            m_cv;
   logic [2:0]      m_cmd;
   int              m_bk;
   logic [RA_W-1:0] m_addr;
   int              e_cls, e_bk;

   sal_cmd_sched #(.NUM_BANKS(N), .RA_W(RA_W), .CA_W(CA_W), .TW(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .act_req_i(act_r), .rd_req_i(rd_r), .wr_req_i(wr_r),
      .pre_req_i(pre_r), .ref_req_i(ref_r),
      .ra_i(ra), .ca_i(ca),
      .t_rrd_m1(trrd), .t_ccd_m1(tccd), .t_wtr_m1(twtr), .t_rtw_m1(trtw),
      .act_gnt_o(act_gnt), .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt),
      .pre_gnt_o(pre_gnt), .ref_gnt_o(ref_gnt),
      .cmd_valid_o(cmd_valid), .cmd_o(cmd), .cmd_bk_o(cmd_bk), .cmd_addr_o(cmd_addr)
   );

   assign dut_gnt = {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]   act, rd, pre, rf;
      logic [5*N-1:0] gnt;
      logic           cv;
      logic [2:0]     cmd;
      logic [BW-1:0]  bk;
   } vec_t;
   vec_t tbl[17];

   function automatic logic [5*N-1:0] g(input logic [N-1:0] a, input logic [N-1:0] r,
                                        input logic [N-1:0] w, input logic [N-1:0] p,
                                        input logic [N-1:0] f);
      return {a, r, w, p, f};
   endfunction

   task automatic setv(input int i, input logic [N-1:0] a, input logic [N-1:0] r,
                       input logic [N-1:0] p, input logic [N-1:0] f, input logic [5*N-1:0] gn,
                       input logic cv, input logic [2:0] c, input logic [BW-1:0] b);
      tbl[i].act = a; tbl[i].rd = r; tbl[i].pre = p; tbl[i].rf = f;
      tbl[i].gnt = gn; tbl[i].cv = cv; tbl[i].cmd = c; tbl[i].bk = b;
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] req, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (req[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [5*N-1:0] exp_gnt(input int cls, input int bk);
      logic [N-1:0] oh, z;
      oh = '0; z = '0;
      if (cls != 0) oh[bk] = 1'b1;
      case (cls)
         1: return {oh, z, z, z, z};
         2: return {z, oh, z, z, z};
         3: return {z, z, oh, z, z};
         4: return {z, z, z, oh, z};
         5: return {z, z, z, z, oh};
         default: return '0;
      endcase
   endfunction

   task automatic model_reset();
      m_rrd = 0; m_ccd = 0; m_wtr = 0; m_rtw = 0;
      for (int i = 0; i < 4; i++) m_ptr[i] = 0;
      m_cv = 1'b0; m_cmd = 3'd0; m_bk = 0; m_addr = '0;
   endtask

   task automatic model_eval();
      logic [N-1:0] rdm, wrm, colm;
      rdm  = (m_ccd == 0 && m_wtr == 0) ? rd_r : '0;
      wrm  = (m_ccd == 0 && m_rtw == 0) ? wr_r : '0;
      colm = rdm | wrm;
      e_cls = 0; e_bk = 0;
      if (ref_r != 0) begin
         e_cls = 5; e_bk = pick(ref_r, m_ptr[0]);
      end else if (colm != 0) begin
         e_bk = pick(colm, m_ptr[1]);
         e_cls = rdm[e_bk] ? 2 : 3;
      end else if (act_r != 0 && m_rrd == 0) begin
         e_cls = 1; e_bk = pick(act_r, m_ptr[2]);
      end else if (pre_r != 0) begin
         e_cls = 4; e_bk = pick(pre_r, m_ptr[3]);
      end
   endtask

   task automatic model_update();
      m_rrd = (e_cls == 1) ? int'(trrd) : (m_rrd > 0 ? m_rrd - 1 : 0);
      m_ccd = (e_cls == 2 || e_cls == 3) ? int'(tccd) : (m_ccd > 0 ? m_ccd - 1 : 0);
      m_wtr = (e_cls == 3) ? int'(twtr) : (m_wtr > 0 ? m_wtr - 1 : 0);
      m_rtw = (e_cls == 2) ? int'(trtw) : (m_rtw > 0 ? m_rtw - 1 : 0);
      case (e_cls)
         5:       m_ptr[0] = (e_bk + 1) % N;
         2, 3:    m_ptr[1] = (e_bk + 1) % N;
         1:       m_ptr[2] = (e_bk + 1) % N;
         4:       m_ptr[3] = (e_bk + 1) % N;
         default: ;
      endcase
      m_cv   = (e_cls != 0);
      m_cmd  = 3'(e_cls);
      m_bk   = (e_cls != 0) ? e_bk : 0;
      m_addr = '0;
      if (e_cls == 1) m_addr = RA_W'(ra >> (e_bk * RA_W));
      if (e_cls == 2 || e_cls == 3) m_addr = RA_W'(CA_W'(ca >> (e_bk * CA_W)));
   endtask

   // Called one time unit after a rising edge, once inputs are driven.
   task automatic sample(input string tag);
      #3;
      model_eval();
      chk($sformatf("%s_gnt", tag), 64'(dut_gnt), 64'(exp_gnt(e_cls, e_bk)));
      chk($sformatf("%s_cmd", tag), 64'({cmd_valid, cmd, cmd_bk, cmd_addr}),
          64'({m_cv, m_cmd, BW'(m_bk), m_addr}));
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_reqs();
      act_r = '0; rd_r = '0; wr_r = '0; pre_r = '0; ref_r = '0;
   endtask

   function automatic logic [N-1:0] rnd_req();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 2) == 0);
      return v;
   endfunction

   initial begin
      int found;
      rst_n = 1'b0;
      act_r = '1; rd_r = '1; wr_r = '1; pre_r = '1; ref_r = '1;
      ra = '0; ca = '0;
      trrd = '0; tccd = '0; twtr = '0; trtw = '0;
      model_reset();

      // Reset with every request high: nothing granted, command path idle.
      repeat (3) @(posedge clk);
      #3;
      chk("rst_gnt", 64'(dut_gnt), 64'd0);
      chk("rst_cmd", 64'({cmd_valid, cmd, cmd_bk, cmd_addr}), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      sample("rel");
      chk("rel_ref_gnt", 64'(ref_gnt), 64'(4'b0001));
      advance();
      idle_reqs();
      sample("drain");
      advance();

      // Directed table: tRRD, RR fairness, class priority.
      setv(0,  4'b0011, 4'b0000, 4'b0000, 4'b0000, g(4'b0001, 0, 0, 0, 0), 0, 0, 0);
      setv(1,  4'b0011, 4'b0000, 4'b0000, 4'b0000, '0,                     1, 1, 0);
      setv(2,  4'b0011, 4'b0000, 4'b0000, 4'b0000, '0,                     0, 0, 0);
      setv(3,  4'b0011, 4'b0000, 4'b0000, 4'b0000, '0,                     0, 0, 0);
      setv(4,  4'b0011, 4'b0000, 4'b0000, 4'b0000, g(4'b0010, 0, 0, 0, 0), 0, 0, 0);
      setv(5,  4'b0000, 4'b0000, 4'b0000, 4'b0000, '0,                     1, 1, 1);
      setv(6,  4'b0000, 4'b1111, 4'b0000, 4'b0000, g(0, 4'b0001, 0, 0, 0), 0, 0, 0);
      setv(7,  4'b0000, 4'b1111, 4'b0000, 4'b0000, g(0, 4'b0010, 0, 0, 0), 1, 2, 0);
      setv(8,  4'b0000, 4'b1111, 4'b0000, 4'b0000, g(0, 4'b0100, 0, 0, 0), 1, 2, 1);
      setv(9,  4'b0000, 4'b1111, 4'b0000, 4'b0000, g(0, 4'b1000, 0, 0, 0), 1, 2, 2);
      setv(10, 4'b0000, 4'b1111, 4'b0000, 4'b0000, g(0, 4'b0001, 0, 0, 0), 1, 2, 3);
      setv(11, 4'b0000, 4'b0000, 4'b0000, 4'b0000, '0,                     1, 2, 0);
      setv(12, 4'b0100, 4'b0010, 4'b1000, 4'b0001, g(0, 0, 0, 0, 4'b0001), 0, 0, 0);
      setv(13, 4'b0100, 4'b0010, 4'b1000, 4'b0000, g(0, 4'b0010, 0, 0, 0), 1, 5, 0);
      setv(14, 4'b0100, 4'b0000, 4'b1000, 4'b0000, g(4'b0100, 0, 0, 0, 0), 1, 2, 1);
      setv(15, 4'b0000, 4'b0000, 4'b1000, 4'b0000, g(0, 0, 0, 4'b1000, 0), 1, 1, 2);
      setv(16, 4'b0000, 4'b0000, 4'b0000, 4'b0000, '0,                     1, 4, 3);
      trrd = 5'd3; tccd = 5'd0; twtr = 5'd0; trtw = 5'd0;
      for (int i = 0; i < 17; i++) begin
         act_r = tbl[i].act; rd_r = tbl[i].rd; wr_r = '0;
         pre_r = tbl[i].pre; ref_r = tbl[i].rf;
         sample($sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d_vec_gnt", i), 64'(dut_gnt), 64'(tbl[i].gnt));
         chk($sformatf("tbl%0d_vec_cmd", i), 64'({cmd_valid, cmd, cmd_bk}),
             64'({tbl[i].cv, tbl[i].cmd, tbl[i].bk}));
         advance();
      end

      // tWTR: RD held off five cycles after WR while ACT falls through.
      trrd = 5'd0; tccd = 5'd0; twtr = 5'd5;
      idle_reqs();
      wr_r = 4'b0100;
      sample("wtr_c0");
      chk("wtr_wr_gnt", 64'(wr_gnt), 64'(4'b0100));
      advance();
      wr_r = '0; rd_r = 4'b0010; act_r = 4'b1000;
      sample("wtr_c1");
      chk("wtr_act_gnt", 64'(act_gnt), 64'(4'b1000));
      advance();
      act_r = '0;
      found = -1;
      for (int k = 2; k < 12; k++) begin
         sample($sformatf("wtr_c%0d", k));
         if (rd_gnt != '0) found = k;
         advance();
         if (found >= 0) break;
      end
      chk("wtr_rd_cycle", 64'(found), 64'(6));
      idle_reqs();
      sample("wtr_drain");
      advance();

      // Address path: ACT carries the row, RD the zero-extended column.
      act_r = 4'b0100;
      ra[2*RA_W +: RA_W] = 16'h1234;
      sample("adr_act");
      advance();
      act_r = '0; rd_r = 4'b0100;
      ca[2*CA_W +: CA_W] = 10'h2AB;
      sample("adr_rd");
      chk("adr_act_cmd", 64'({cmd_valid, cmd, cmd_bk, cmd_addr}), 64'({1'b1, 3'd1, 2'd2, 16'h1234}));
      advance();
      rd_r = '0;
      sample("adr_done");
      chk("adr_rd_cmd", 64'({cmd_valid, cmd, cmd_bk, cmd_addr}), 64'({1'b1, 3'd2, 2'd2, 16'h02AB}));
      advance();

      // Mid-operation reset: immediate clear, arbitration restarts at bank 0.
      tccd = 5'd2;
      rd_r = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         sample($sformatf("mid_c%0d", k));
         advance();
      end
      rst_n = 1'b0;
      #1;
      chk("mid_rst_gnt", 64'(dut_gnt), 64'd0);
      chk("mid_rst_cmd", 64'({cmd_valid, cmd, cmd_bk, cmd_addr}), 64'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sample("mid_rel");
      chk("mid_rel_rd_gnt", 64'(rd_gnt), 64'(4'b0001));
      advance();

      // Random traffic against the model.
      for (int c = 0; c < 400; c++) begin
         if (c % 16 == 0) begin
            trrd = 5'($urandom_range(0, 3));
            tccd = 5'($urandom_range(0, 3));
            twtr = 5'($urandom_range(0, 4));
            trtw = 5'($urandom_range(0, 4));
         end
         act_r = rnd_req();
         rd_r  = rnd_req();
         wr_r  = rnd_req();
         pre_r = rnd_req();
         ref_r = ($urandom_range(0, 7) == 0) ? rnd_req() : '0;
         ra    = {$urandom(), $urandom()};
         ca    = 40'({$urandom(), $urandom()});
         sample($sformatf("rnd%0d", c));
         advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sal_cmd_sched.md
Name: sal_cmd_sched

Overview:
- Per-channel command scheduler, placed between the per-bank controllers and the DDR command path.
- Collects act/rd/wr/pre/ref requests from NUM_BANKS bank controllers.
- Enforces inter-bank timing (tRRD, tCCD, tWTR, tRTW) and returns at most one same-cycle grant.
- Drives a registered one-command-per-cycle DRAM command output.

Parameters:
NUM_BANKS, 4, number of bank controllers served (power of 2, 2..16)
RA_W, 16, row address width
CA_W, 10, column address width (must be <= RA_W)
TW, 5, width of timing inputs

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
act_req_i  in  NUM_BANKS  per-bank ACT request
rd_req_i  in  NUM_BANKS  per-bank READ request
wr_req_i  in  NUM_BANKS  per-bank WRITE request
pre_req_i  in  NUM_BANKS  per-bank PRECHARGE request
ref_req_i  in  NUM_BANKS  per-bank REFRESH request
ra_i  in  NUM_BANKS*RA_W  per-bank row address, bank b at [b*RA_W +: RA_W]
ca_i  in  NUM_BANKS*CA_W  per-bank column address, same packing
t_rrd_m1  in  TW  tRRD-1 (ACT to ACT, any bank)
t_ccd_m1  in  TW  tCCD-1 (column to column)
t_wtr_m1  in  TW  WR-to-RD spacing minus 1
t_rtw_m1  in  TW  RD-to-WR spacing minus 1
act_gnt_o  out  NUM_BANKS  one-hot ACT grant
rd_gnt_o  out  NUM_BANKS  one-hot READ grant
wr_gnt_o  out  NUM_BANKS  one-hot WRITE grant
pre_gnt_o  out  NUM_BANKS  one-hot PRECHARGE grant
ref_gnt_o  out  NUM_BANKS  one-hot REFRESH grant
cmd_valid_o  out  1  command issued this cycle
cmd_o  out  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF
cmd_bk_o  out  log2(NUM_BANKS)  target bank
cmd_addr_o  out  RA_W  ra for ACT, zero-extended ca for RD/WR, 0 otherwise

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all timing counters 0, all RR pointers 0, cmd_valid_o=0, cmd_o=0, cmd_bk_o=0, cmd_addr_o=0.
- Grants are combinational from current requests and registered state, in the same cycle as the request. Grants are never asserted while rst_n=0.
- At most one bit set across all five grant vectors per cycle.
- A grant bit is set only where the corresponding request bit is 1.
- Masking:
  - act requests are masked while rrd_cnt!=0.
  - rd requests are masked while ccd_cnt!=0 or wtr_cnt!=0.
  - wr requests are masked while ccd_cnt!=0 or rtw_cnt!=0.
  - pre and ref requests are never masked.
- Column class = rd|wr after masking. If a bank asserts rd and wr together (illegal), RD is granted and WR ignored.
- Class priority: REF > COL > ACT > PRE. The highest class with any unmasked request wins. A masked higher class does not block a lower class.
- Round-robin within a class:
  - Each class (REF, COL, ACT, PRE) has its own pointer.
  - The winner is the first requesting bank at index >= pointer, wrapping modulo NUM_BANKS.
  - On a grant, that class pointer becomes (winner+1) mod NUM_BANKS. Other pointers hold.
- Timing counters (down counters, saturate at 0):
  - ACT grant loads rrd_cnt=t_rrd_m1.
  - RD or WR grant loads ccd_cnt=t_ccd_m1.
  - WR grant loads wtr_cnt=t_wtr_m1.
  - RD grant loads rtw_cnt=t_rtw_m1.
  - Otherwise each nonzero counter decrements by 1 per cycle.
  - A value of m1=0 permits back-to-back grants.
  - Load takes precedence over decrement.
- Command output: registered, one cycle after the grant cycle. cmd_valid_o=1, cmd_o/cmd_bk_o/cmd_addr_o come from the granted class, bank and address sampled in the grant cycle.
- No grant: cmd_valid_o=0, cmd_o=0, cmd_bk_o=0 and cmd_addr_o=0 on the next cycle.
- Reset mid-operation: all state clears immediately (asynchronous). Pending requests are re-arbitrated from pointer 0 after release.

Test Plan:
- Reset: hold rst_n=0 with all requests at 1 -> all grants 0, cmd_valid_o=0, cmd_o=0. After release, first grant is ref_gnt_o=0001.
- tRRD: t_rrd_m1=3, act_req_i=0011 held -> act_gnt_o=0001 at cycle 0, 0010 at cycle 4; cmd_o=1 at cycles 1 and 5 with cmd_bk_o 0 then 1.
- RR fairness: t_ccd_m1=0, rd_req_i=1111 held -> rd_gnt_o=0001,0010,0100,1000,0001 on consecutive cycles.
- tWTR with fall-through: WR bank2 granted at cycle 0, t_wtr_m1=5, t_rrd_m1=0. From cycle 1, rd_req_i=0010 and act_req_i=1000 -> ACT bank3 granted at cycle 1, RD bank1 granted at cycle 6.
- Priority: same cycle ref bank0, rd bank1, act bank2, pre bank3 all held -> REF b0, RD b1, ACT b2, PRE b3 on cycles 0..3 (each request dropped after its grant).
- Address: act bank2 with ra=0x1234 -> next cycle cmd_valid_o=1, cmd_o=1, cmd_bk_o=2, cmd_addr_o=0x1234. Then rd bank2 with ca=0x2AB -> cmd_o=2, cmd_addr_o=0x02AB.
